// File: rtl/laser_dlp_xtrig_sequencer_avmm.sv
`default_nettype none
// ============================================================================
// Module      : laser_dlp_xtrig_sequencer_avmm
// Description : Avalon-MM master that programs one laser/DLP/XTRIG capture
//               cycle into laser_dlp_xtrig_controller_avms, starts it, polls
//               the done bit (readdata[6]) with a timeout, then clears start.
// Ports       : master_clk/master_reset  - clock, sync active-high reset
//               cmd_*                     - one-shot command handshake
//               master_*                  - Avalon-MM master port
//               busy_o/done_o/error_o     - status (done/error are pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module laser_dlp_xtrig_sequencer_avmm #(
  parameter int          DATA_WIDTH    = 32,
  parameter logic [15:0] POLL_INTERVAL = 16'd1000,
  parameter logic [15:0] TIMEOUT_POLLS = 16'd1000
) (
  input  logic                      master_clk,
  input  logic                      master_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [4:0]                cmd_enables,
  input  logic [7:0]                cmd_num_pulse,
  input  logic [15:0]               cmd_dlp_delay,
  input  logic [15:0]               cmd_xtrig_delay,
  input  logic [15:0]               cmd_exposure,
  input  logic [15:0]               cmd_data_write,
  output logic [1:0]                master_address,
  output logic [DATA_WIDTH/8-1:0]   master_byteenable,
  output logic                      master_write,
  output logic                      master_read,
  output logic [DATA_WIDTH-1:0]     master_writedata,
  input  logic [DATA_WIDTH-1:0]     master_readdata,
  input  logic                      master_readdatavalid,
  input  logic                      master_waitrequest,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_CTRL   = 4'd1,
    WR_DLY_A  = 4'd2,
    WR_DLY_B  = 4'd3,
    WR_EXP_A  = 4'd4,
    WR_EXP_B  = 4'd5,
    WR_START  = 4'd6,
    POLL_WAIT = 4'd7,
    RD_REQ    = 4'd8,
    RD_WAIT   = 4'd9,
    WR_CLEAR  = 4'd10
  } state_t;

  state_t      state, state_nx;

  logic [4:0]  enables_q;
  logic [7:0]  num_pulse_q;
  logic [15:0] dlp_delay_q, xtrig_delay_q, exposure_q, data_write_q;
  logic [15:0] wait_cnt, poll_cnt, poll_next;
  logic        success;

  logic [31:0] word_ctrl_stop, word_ctrl_start, word_dly, word_exp;

  logic        accept;
  logic        status_done;
  logic        unused_readdata;

  assign word_ctrl_stop  = {16'h0000, num_pulse_q, 2'b00, 1'b0, enables_q};
  assign word_ctrl_start = {16'h0000, num_pulse_q, 2'b00, 1'b1, enables_q};
  assign word_dly        = {dlp_delay_q, xtrig_delay_q};
  assign word_exp        = {exposure_q, data_write_q};

  assign accept            = (state == IDLE) && cmd_valid;
  assign cmd_ready         = (state == IDLE);
  assign busy_o            = (state != IDLE);
  assign master_byteenable = '1;
  assign status_done       = master_readdata[6];
  assign unused_readdata   = ^{master_readdata[DATA_WIDTH-1:7], master_readdata[5:0]};

  // Saturating increment so the poll count never wraps.
  assign poll_next = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

  // Outputs are decoded from state so that address/data/request stay stable
  // for as long as the slave holds waitrequest.
  always_comb begin
    state_nx         = state;
    master_write     = 1'b0;
    master_read      = 1'b0;
    master_address   = 2'd0;
    master_writedata = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nx = WR_CTRL;
      end
      WR_CTRL: begin
        master_write            = 1'b1;
        master_writedata[31:0]  = word_ctrl_stop;
        if (!master_waitrequest) state_nx = WR_DLY_A;
      end
      WR_DLY_A, WR_DLY_B: begin
        master_write            = 1'b1;
        master_address          = 2'd1;
        master_writedata[31:0]  = word_dly;
        if (!master_waitrequest) state_nx = (state == WR_DLY_A) ? WR_DLY_B : WR_EXP_A;
      end
      WR_EXP_A, WR_EXP_B: begin
        master_write            = 1'b1;
        master_address          = 2'd2;
        master_writedata[31:0]  = word_exp;
        if (!master_waitrequest) state_nx = (state == WR_EXP_A) ? WR_EXP_B : WR_START;
      end
      WR_START: begin
        master_write            = 1'b1;
        master_writedata[31:0]  = word_ctrl_start;
        if (!master_waitrequest) state_nx = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (wait_cnt == POLL_INTERVAL - 16'd1) state_nx = RD_REQ;
      end
      RD_REQ: begin
        master_read = 1'b1;
        if (!master_waitrequest) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (master_readdatavalid) begin
          if (status_done)                     state_nx = WR_CLEAR;
          else if (poll_next == TIMEOUT_POLLS) state_nx = WR_CLEAR;
          else                                 state_nx = POLL_WAIT;
        end
      end
      WR_CLEAR: begin
        master_write            = 1'b1;
        master_writedata[31:0]  = word_ctrl_stop;
        if (!master_waitrequest) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (master_reset) begin
      state         <= IDLE;
      enables_q     <= '0;
      num_pulse_q   <= '0;
      dlp_delay_q   <= '0;
      xtrig_delay_q <= '0;
      exposure_q    <= '0;
      data_write_q  <= '0;
      wait_cnt      <= '0;
      poll_cnt      <= '0;
      success       <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      state   <= state_nx;
      done_o  <= 1'b0;
      error_o <= 1'b0;

      if (accept) begin
        enables_q     <= cmd_enables;
        num_pulse_q   <= cmd_num_pulse;
        dlp_delay_q   <= cmd_dlp_delay;
        xtrig_delay_q <= cmd_xtrig_delay;
        exposure_q    <= cmd_exposure;
        data_write_q  <= cmd_data_write;
        poll_cnt      <= '0;
        success       <= 1'b0;
      end

      // Interval counter restarts on every entry to POLL_WAIT.
      wait_cnt <= (state == POLL_WAIT) ? wait_cnt + 16'd1 : 16'd0;

      if (state == RD_WAIT && master_readdatavalid) begin
        if (status_done) success  <= 1'b1;
        else             poll_cnt <= poll_next;
      end

      // Completion is reported in the cycle after the clear write lands.
      if (state == WR_CLEAR && !master_waitrequest) begin
        done_o  <= success;
        error_o <= ~success;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_dlp_xtrig_sequencer_avmm.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_dlp_xtrig_sequencer_avmm
// Description : Self-checking bench for laser_dlp_xtrig_sequencer_avmm with an
//               Avalon slave model and an expected-transfer scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_dlp_xtrig_sequencer_avmm;

  localparam int          DW = 32;
  localparam logic [15:0] PI = 16'd4;
  localparam logic [15:0] TP = 16'd3;

  logic              master_clk = 1'b0;
  logic              master_reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_enables;
  logic [7:0]        cmd_num_pulse;
  logic [15:0]       cmd_dlp_delay, cmd_xtrig_delay, cmd_exposure, cmd_data_write;
  logic [1:0]        master_address;
  logic [DW/8-1:0]   master_byteenable;
  logic              master_write, master_read;
  logic [DW-1:0]     master_writedata;
  logic [DW-1:0]     master_readdata;
  logic              master_readdatavalid;
  logic              master_waitrequest;
  logic              busy_o, done_o, error_o;

  always #5 master_clk = ~master_clk;

  laser_dlp_xtrig_sequencer_avmm #(
    .DATA_WIDTH(DW), .POLL_INTERVAL(PI), .TIMEOUT_POLLS(TP)
  ) dut (
    .master_clk(master_clk), .master_reset(master_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_enables(cmd_enables), .cmd_num_pulse(cmd_num_pulse),
    .cmd_dlp_delay(cmd_dlp_delay), .cmd_xtrig_delay(cmd_xtrig_delay),
    .cmd_exposure(cmd_exposure), .cmd_data_write(cmd_data_write),
    .master_address(master_address), .master_byteenable(master_byteenable),
    .master_write(master_write), .master_read(master_read),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfer record: {is_read, address, data}; reads carry zero data.
  logic [34:0] exp_q[$];
  logic [34:0] mon_req, mon_exp, pend_req;
  logic        pend;
  int done_cnt, err_cnt, wr_cnt, rd_num, done_on_read, rd_cd;
  bit rand_wait, hold_wait;

  function automatic logic [31:0] ctrl_w(input logic [4:0] en, input logic [7:0] np, input logic st);
    return {16'h0000, np, 2'b00, st, en};
  endfunction

  task automatic push_cmd(input logic [4:0] en, input logic [7:0] np,
                          input logic [15:0] dd, input logic [15:0] xd,
                          input logic [15:0] ex, input logic [15:0] wd, input int nreads);
    exp_q.push_back({1'b0, 2'd0, ctrl_w(en, np, 1'b0)});
    exp_q.push_back({1'b0, 2'd1, dd, xd});
    exp_q.push_back({1'b0, 2'd1, dd, xd});
    exp_q.push_back({1'b0, 2'd2, ex, wd});
    exp_q.push_back({1'b0, 2'd2, ex, wd});
    exp_q.push_back({1'b0, 2'd0, ctrl_w(en, np, 1'b1)});
    for (int i = 0; i < nreads; i++) exp_q.push_back({1'b1, 2'd0, 32'h0});
    exp_q.push_back({1'b0, 2'd0, ctrl_w(en, np, 1'b0)});
    wr_cnt = 0;
    rd_num = 0;
  endtask

  task automatic drive_cmd(input logic [4:0] en, input logic [7:0] np,
                           input logic [15:0] dd, input logic [15:0] xd,
                           input logic [15:0] ex, input logic [15:0] wd);
    cmd_enables = en; cmd_num_pulse = np; cmd_dlp_delay = dd;
    cmd_xtrig_delay = xd; cmd_exposure = ex; cmd_data_write = wd;
    cmd_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge master_clk);
    #3;
  endtask

  task automatic wait_end(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_o || error_o) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Slave model and monitor: decide waitrequest for the coming edge, then
  // judge the request the DUT is presenting against that decision.
  always @(negedge master_clk) begin
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin
        rd_num++;
        master_readdatavalid = 1'b1;
        master_readdata      = $urandom;
        master_readdata[6]   = (done_on_read != 0) && (rd_num >= done_on_read);
      end
    end

    master_waitrequest = hold_wait ? 1'b1 : (rand_wait ? 1'($urandom_range(0, 1)) : 1'b0);

    if (!master_reset && (master_write || master_read)) begin
      if (master_write && master_read) chk("wr_rd_both", 1, 0);
      mon_req = master_read ? {1'b1, master_address, 32'h0}
                            : {1'b0, master_address, master_writedata[31:0]};
      if (pend) chk("req_stable", mon_req, pend_req);
      if (!master_waitrequest) begin
        pend = 1'b0;
        chk("xfer_extra", exp_q.size() == 0, 0);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("xfer", mon_req, mon_exp);
        end
        if (master_write) wr_cnt++;
        else rd_cd = rand_wait ? $urandom_range(1, 3) : 1;
      end else begin
        pend     = 1'b1;
        pend_req = mon_req;
      end
    end else begin
      if (pend && !master_reset) chk("req_dropped", 0, 1);
      pend = 1'b0;
    end

    if (done_o) done_cnt++;
    if (error_o) err_cnt++;
    if (done_o && error_o) chk("done_err_both", 1, 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit got;

  initial begin
    master_reset = 1'b1; cmd_valid = 1'b0;
    cmd_enables = '0; cmd_num_pulse = '0; cmd_dlp_delay = '0;
    cmd_xtrig_delay = '0; cmd_exposure = '0; cmd_data_write = '0;
    master_waitrequest = 1'b0; master_readdatavalid = 1'b0; master_readdata = '0;
    done_cnt = 0; err_cnt = 0; wr_cnt = 0; rd_num = 0; rd_cd = 0;
    done_on_read = 1; rand_wait = 1'b0; hold_wait = 1'b0; pend = 1'b0;

    repeat (3) tick();
    master_reset = 1'b0;
    tick();
    chk("rst_write", master_write, 0);
    chk("rst_read", master_read, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_addr", master_address, 0);
    chk("rst_wdata", master_writedata, 0);
    chk("rst_be", master_byteenable, 4'hF);
    chk("rst_done_err", {done_o, error_o}, 0);

    // Zero-waitrequest run, done on the 2nd read, with cycle-exact timing.
    done_on_read = 2;
    push_cmd(5'b00111, 8'd8, 16'd100, 16'd300, 16'd50, 16'd400, 2);
    drive_cmd(5'b00111, 8'd8, 16'd100, 16'd300, 16'd50, 16'd400);
    chk("t1_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t1_write_run", master_write, 1);
      tick();
    end
    for (int i = 0; i < PI; i++) begin
      chk("t1_poll_gap", {master_write, master_read}, 0);
      tick();
    end
    chk("t1_first_read", master_read, 1);
    wait_end(200, got);
    chk("t1_end_seen", got, 1);
    chk("t1_done", done_o, 1);
    chk("t1_ready_at_done", cmd_ready, 1);
    tick();
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_idle", busy_o, 0);

    // Random waitrequest and read latency; inputs scrambled while busy.
    rand_wait = 1'b1;
    done_on_read = 2;
    push_cmd(5'b11010, 8'd200, 16'hBEEF, 16'h1234, 16'h0F0F, 16'hA5A5, 2);
    drive_cmd(5'b11010, 8'd200, 16'hBEEF, 16'h1234, 16'h0F0F, 16'hA5A5);
    tick();
    cmd_valid = 1'b0;
    drive_cmd(5'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    cmd_valid = 1'b0;
    wait_end(2000, got);
    chk("t2_end_seen", got, 1);
    tick();
    chk("t2_done_cnt", done_cnt, 2);
    chk("t2_err_cnt", err_cnt, 0);
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_idle", busy_o, 0);
    rand_wait = 1'b0;
    repeat (4) tick();

    // Status never set: timeout after TP reads.
    done_on_read = 0;
    push_cmd(5'b00001, 8'd1, 16'd2, 16'd3, 16'd4, 16'd5, TP);
    drive_cmd(5'b00001, 8'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    tick();
    cmd_valid = 1'b0;
    wait_end(500, got);
    chk("t3_end_seen", got, 1);
    chk("t3_error", error_o, 1);
    chk("t3_no_done", done_o, 0);
    tick();
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_done_cnt", done_cnt, 2);
    chk("t3_q_empty", exp_q.size(), 0);

    // Reset during WR_DLY_B under waitrequest, then a fresh command.
    done_on_read = 1;
    push_cmd(5'b00011, 8'd4, 16'd7, 16'd8, 16'd9, 16'd10, 1);
    drive_cmd(5'b00011, 8'd4, 16'd7, 16'd8, 16'd9, 16'd10);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_cnt == 2 && master_write) break;
      tick();
    end
    chk("t4_reached_dly_b", {wr_cnt[7:0], master_write, master_address}, {8'd2, 1'b1, 2'd1});
    hold_wait = 1'b1;
    master_reset = 1'b1;
    tick();
    chk("t4_rst_write", master_write, 0);
    chk("t4_rst_busy", busy_o, 0);
    chk("t4_rst_ready", cmd_ready, 1);
    master_reset = 1'b0;
    hold_wait = 1'b0;
    exp_q.delete();
    tick();
    push_cmd(5'b10101, 8'd3, 16'd11, 16'd12, 16'd13, 16'd14, 1);
    drive_cmd(5'b10101, 8'd3, 16'd11, 16'd12, 16'd13, 16'd14);
    tick();
    cmd_valid = 1'b0;
    wait_end(500, got);
    chk("t4_end_seen", got, 1);
    tick();
    chk("t4_done_cnt", done_cnt, 3);
    chk("t4_q_empty", exp_q.size(), 0);

    // Back-to-back: valid held high, second command taken in the done cycle.
    done_on_read = 1;
    push_cmd(5'b00100, 8'd16, 16'd21, 16'd22, 16'd23, 16'd24, 1);
    push_cmd(5'b01000, 8'd32, 16'd31, 16'd32, 16'd33, 16'd34, 1);
    drive_cmd(5'b00100, 8'd16, 16'd21, 16'd22, 16'd23, 16'd24);
    tick();
    drive_cmd(5'b01000, 8'd32, 16'd31, 16'd32, 16'd33, 16'd34);
    wait_end(500, got);
    chk("t5_first_end", got, 1);
    chk("t5_first_done", done_o, 1);
    chk("t5_ready_at_done", cmd_ready, 1);
    tick();
    chk("t5_second_wr_ctrl", {busy_o, master_write, master_address, master_writedata[31:0]},
        {1'b1, 1'b1, 2'd0, ctrl_w(5'b01000, 8'd32, 1'b0)});
    cmd_valid = 1'b0;
    wait_end(500, got);
    chk("t5_second_end", got, 1);
    tick();
    chk("t5_done_cnt", done_cnt, 5);
    chk("t5_err_cnt", err_cnt, 1);
    chk("t5_q_empty", exp_q.size(), 0);
    chk("t5_idle", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/laser_dlp_xtrig_sequencer_avmm.md
# laser_dlp_xtrig_sequencer_avmm

Avalon-MM master that programs and runs one laser/DLP/XTRIG capture cycle on the `laser_dlp_xtrig_controller_avms` register map. A single command handshake loads enables, pulse count and timing fields. The block issues the register writes in the order the slave needs, starts the cycle, polls the done status bit with a timeout, then clears the start bit. It sits between the capture-control logic and the controller's Avalon slave port on the same fabric.

## Interface
- `DATA_WIDTH`, 32, Avalon data width; byteenable is `DATA_WIDTH/8` bits.
- `POLL_INTERVAL`, 16'd1000, idle cycles before each status read (minimum 1).
- `TIMEOUT_POLLS`, 16'd1000, maximum status reads before abort (minimum 1).

Ports:
- `master_clk`  in  1  block clock; also the slave's clock.
- `master_reset`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_enables`  in  5  {xtrig_mode, blue_en, red_en, xtrig_en, dlp_en}.
- `cmd_num_pulse`  in  8  XTRIG pulse count.
- `cmd_dlp_delay`, `cmd_xtrig_delay`, `cmd_exposure`, `cmd_data_write`  in  16 each  timing fields.
- `master_address`  out  2  word address.
- `master_byteenable`  out  DATA_WIDTH/8  held all-ones.
- `master_write`, `master_read`  out  1  Avalon requests.
- `master_writedata`  out  DATA_WIDTH  write data.
- `master_readdata`  in  DATA_WIDTH  read data; only bit 6 is used.
- `master_readdatavalid`  in  1  read response strobe.
- `master_waitrequest`  in  1  slave stall.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle pulse when a cycle completes normally.
- `error_o`  out  1  one-cycle pulse on poll timeout.

## Operation
- Command accept: on `cmd_valid && cmd_ready`, all `cmd_*` fields are latched into internal registers. Later input changes have no effect.
- Word encodings:
  - addr 0: [5]=start, [4:0]=enables, [15:8]=num_pulse, all other bits 0.
  - addr 1: [31:16]=dlp_delay, [15:0]=xtrig_delay.
  - addr 2: [31:16]=exposure, [15:0]=data_write.
- Write order: WR_CTRL, WR_DLY_A, WR_DLY_B, WR_EXP_A, WR_EXP_B, WR_START, POLL_WAIT, RD_REQ, RD_WAIT, WR_CLEAR, IDLE.
  - WR_CTRL writes addr 0 with start=0.
  - WR_DLY_A and WR_DLY_B write addr 1 with identical data.
  - WR_EXP_A and WR_EXP_B write addr 2 with identical data.
  - WR_START writes addr 0 with start=1.
  - WR_CLEAR writes addr 0 with start=0 and the same enables.
- Duplicate writes are mandatory. The slave computes its difference registers from the previously stored field values, so the second write of each pair makes the differences correct.
- Write transfer: address, writedata and `master_write` are held stable while `master_waitrequest`=1. The transfer completes on the first edge where write=1 and waitrequest=0, and the FSM advances on that edge.
- POLL_WAIT: counts `POLL_INTERVAL` cycles, then moves to RD_REQ.
- RD_REQ: `master_read`=1 with address 0, held until waitrequest=0. Read is then deasserted and the FSM moves to RD_WAIT.
- RD_WAIT: waits for `master_readdatavalid`.
  - `readdata[6]`=1: go to WR_CLEAR, marked successful.
  - `readdata[6]`=0: increment the poll count. If the count equals `TIMEOUT_POLLS`, go to WR_CLEAR marked failed; otherwise return to POLL_WAIT.
- Poll count: 16-bit, cleared on command accept, never wraps.
- `readdatavalid` outside RD_WAIT is ignored.
- `master_write` and `master_read` are never high in the same cycle.

## Timing
- Reset values: state=IDLE; `master_write`, `master_read`, `busy_o`, `done_o`, `error_o` = 0; `master_address`=0; `master_writedata`=0; `master_byteenable`=all-ones; `cmd_ready`=1 from the first cycle after reset.
- Reset mid-operation: the next edge forces the reset values, even mid-transfer under waitrequest.
- Accept edge T with zero waitrequest:
  - Writes complete at edges T+1 through T+6; `master_write` is high for 6 consecutive cycles.
  - First `master_read` is asserted `POLL_INTERVAL` cycles after the WR_START completion.
- Each waitrequest-high cycle extends the current transfer by exactly one cycle.
- `done_o` or `error_o` is high in the cycle immediately after the WR_CLEAR write completes. `cmd_ready` rises in that same cycle.
- A command presented in that cycle is accepted.
- `cmd_valid` held high while busy is not accepted and not queued.

## Test plan
- Zero-waitrequest command (enables=5'b00111, num_pulse=8, dlp=100, xtrig=300, exp=50, wr=400), `POLL_INTERVAL`=4, bit6 returned on the 2nd read:
  - addresses 0,1,1,2,2,0,0,0,0 with data 0x0807, 0x0064012C ×2, 0x00320190 ×2, 0x0827, reads, then 0x0807;
  - one `done_o` pulse, `error_o` never high.
- Random waitrequest (50%) with read response latency 1–3: identical write and read sequence, every request held stable until accepted, final state IDLE.
- Bit6 never set, `TIMEOUT_POLLS`=3: exactly 3 reads, then the clear write to addr 0 with bit5=0, one `error_o` pulse, no `done_o`.
- `cmd_*` fields changed while busy: write data stays equal to the values latched at accept.
- `master_reset` asserted during WR_DLY_B with waitrequest=1: the next cycle shows write=0, `busy_o`=0, `cmd_ready`=1. A fresh command then runs the full sequence.
- Back-to-back commands with `cmd_valid` held high: the second is accepted in the `done_o` cycle, and its WR_CTRL write starts the next cycle.
